store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 133 +++++++++++++
 tb/tb_store_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-store buffer between the pipeline MEM stage and data memory.
// Stores queue in a circular FIFO and drain in order; loads forward, stall or bypass.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    ISSUE,
    WAIT
  } drain_e;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    mask_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  drain_e        state_q;

  logic          ld_req, st_req, retire, enq;
  logic          hit, fwd_word, fwd, ld_issue;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  assign ld_req   = cpu_memread & ~cpu_memwrite;
  assign st_req   = cpu_memwrite & ~cpu_memread;
  assign retire   = (state_q == WAIT) && !mem_busy;
  assign enq      = st_req && ((count_q != CW'(DEPTH)) || retire);

  // Scan oldest to newest so the last match seen is the newest matching store.
  always_comb begin
    hit      = 1'b0;
    fwd_word = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx][31:2] == cpu_addr[31:2])) begin
        hit      = 1'b1;
        fwd_word = mask_q[idx][2];
        fwd_data = data_q[idx];
      end
    end
  end

  assign fwd      = hit && cpu_sign_mask[2] && fwd_word;
  assign ld_issue = ld_req && !hit && (state_q == DRAIN_IDLE) && !mem_busy;

  always_comb begin
    cpu_read_data  = '0;
    cpu_stall      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    mem_sign_mask  = '0;
    if (rst_n) begin
      if (st_req) begin
        cpu_stall = !enq;
      end else if (ld_req) begin
        if (fwd) begin
          cpu_read_data = fwd_data;
        end else if (ld_issue) begin
          mem_memread   = 1'b1;
          mem_addr      = cpu_addr;
          mem_sign_mask = cpu_sign_mask;
          cpu_read_data = mem_read_data;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      // Loads only issue in DRAIN_IDLE, so the write path never collides with them.
      if (state_q != DRAIN_IDLE) begin
        mem_addr       = addr_q[head_q];
        mem_write_data = data_q[head_q];
        mem_sign_mask  = mask_q[head_q];
        mem_memwrite   = (state_q == ISSUE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_write_data;
      mask_q[tail_q] <= cpu_sign_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= DRAIN_IDLE;
    end else begin
      if (enq)    tail_q <= tail_q + PW'(1);
      if (retire) head_q <= head_q + PW'(1);
      case ({enq, retire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      case (state_q)
        DRAIN_IDLE: if ((count_q != '0) && !ld_issue && !mem_busy) state_q <= ISSUE;
        ISSUE:      state_q <= WAIT;
        WAIT:       if (!mem_busy) state_q <= DRAIN_IDLE;
        default:    state_q <= DRAIN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random bench for store_buffer against an architectural memory model
// plus an in-order pending-store queue.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
  logic        cpu_memwrite, cpu_memread, cpu_stall;
  logic [3:0]  cpu_sign_mask, mem_sign_mask;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_busy;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_sign_mask(cpu_sign_mask),
    .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } st_t;

  logic [31:0] phys [256];
  logic [31:0] arch [256];
  st_t         pend [$];
  st_t         fl;
  bit          inflight;
  bit          prev_should_issue;
  int          busy_hold;
  bit          busy_rand;
  bit          acc;
  logic [31:0] ld_data;
  logic        ld_mr;
  int          nwrites;
  int          tests;
  int          fails;

  assign mem_read_data = phys[mem_addr[9:2]];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input st_t e);
    logic [31:0] m;
    logic [4:0]  sh;
    if (e.m[2]) return e.d;
    if (e.m[2:1] == 2'b01) return e.a[1] ? {e.d[15:0], old[15:0]} : {old[31:16], e.d[15:0]};
    sh = {e.a[1:0], 3'b000};
    m  = 32'hFF << sh;
    return (old & ~m) | ((e.d & 32'hFF) << sh);
  endfunction

  task automatic monitor();
    int unsigned cnt;
    bit ld, st, idle, retiring, hit, fwd_word, ld_go, exp_stall;
    logic [7:0] w;
    st_t e;
    cnt = pend.size() + (inflight ? 1 : 0);
    ld  = cpu_memread && !cpu_memwrite;
    st  = cpu_memwrite && !cpu_memread;
    w   = cpu_addr[9:2];
    acc = 1'b0;
    idle = !inflight && !mem_memwrite;
    check("rw_exclusive", mem_memread & mem_memwrite, 0);
    check("drain_start", mem_memwrite, prev_should_issue);
    if (mem_memwrite) begin
      if (pend.size() == 0) check("write_when_empty", mem_memwrite, 0);
      else begin
        fl = pend.pop_front();
        inflight = 1'b1;
        nwrites++;
        check("wr_addr", mem_addr, fl.a);
        check("wr_data", mem_write_data, fl.d);
        check("wr_mask", mem_sign_mask, fl.m);
        phys[fl.a[9:2]] = merge(phys[fl.a[9:2]], fl);
      end
    end else if (inflight) begin
      check("wait_addr", mem_addr, fl.a);
      check("wait_data", mem_write_data, fl.d);
      check("wait_mask", mem_sign_mask, fl.m);
    end
    retiring = inflight && !mem_memwrite && !mem_busy;
    hit = 1'b0;
    fwd_word = 1'b0;
    if (inflight && fl.a[31:2] == cpu_addr[31:2]) begin hit = 1'b1; fwd_word = fl.m[2]; end
    foreach (pend[k]) if (pend[k].a[31:2] == cpu_addr[31:2]) begin hit = 1'b1; fwd_word = pend[k].m[2]; end
    ld_go = 1'b0;
    if (st) begin
      exp_stall = (cnt == DEPTH) && !retiring;
      check("st_stall", cpu_stall, exp_stall);
      check("st_memread", mem_memread, 0);
      if (!exp_stall) begin
        e.a = cpu_addr; e.d = cpu_write_data; e.m = cpu_sign_mask;
        pend.push_back(e);
        arch[w] = merge(arch[w], e);
        acc = 1'b1;
      end
    end else if (ld) begin
      if (hit && cpu_sign_mask[2] && fwd_word) begin
        check("fwd_stall", cpu_stall, 0);
        check("fwd_memread", mem_memread, 0);
        check("fwd_data", cpu_read_data, arch[w]);
        acc = 1'b1;
      end else if (hit) begin
        check("conf_stall", cpu_stall, 1);
        check("conf_memread", mem_memread, 0);
      end else if (idle && !mem_busy) begin
        ld_go = 1'b1;
        check("ld_stall", cpu_stall, 0);
        check("ld_memread", mem_memread, 1);
        check("ld_addr", mem_addr, cpu_addr);
        check("ld_mask", mem_sign_mask, cpu_sign_mask);
        check("ld_data", cpu_read_data, arch[w]);
        acc = 1'b1;
      end else begin
        check("ld_wait_stall", cpu_stall, 1);
        check("ld_wait_memread", mem_memread, 0);
      end
      ld_data = cpu_read_data;
      ld_mr   = mem_memread;
    end else begin
      check("noreq_stall", cpu_stall, 0);
      check("noreq_memread", mem_memread, 0);
      acc = 1'b1;
    end
    if (retiring) inflight = 1'b0;
    prev_should_issue = (cnt > 0) && idle && !ld_go && !mem_busy;
  endtask

  task automatic step();
    mem_busy = (busy_hold > 0) ? 1'b1 : (busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
    if (busy_hold > 0) busy_hold--;
    #1;
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int stalls);
    cpu_memwrite = 1'b1; cpu_memread = 1'b0;
    cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m;
    stalls = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (acc) break;
      stalls++;
    end
    check("store_accepted", acc, 1);
    cpu_memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m,
                         output logic [31:0] d, output int stalls, output logic mr);
    cpu_memwrite = 1'b0; cpu_memread = 1'b1;
    cpu_addr = a; cpu_write_data = '0; cpu_sign_mask = m;
    stalls = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (acc) break;
      stalls++;
    end
    check("load_done", acc, 1);
    d  = ld_data;
    mr = ld_mr;
    cpu_memread = 1'b0;
  endtask

  task automatic drain();
    cpu_memwrite = 1'b0; cpu_memread = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (pend.size() == 0 && !inflight) break;
      step();
    end
    check("drain_done", pend.size() + (inflight ? 1 : 0), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_stall"}, cpu_stall, 0);
    check({tag, "_cpu_read_data"}, cpu_read_data, 0);
    check({tag, "_mem_memwrite"}, mem_memwrite, 0);
    check({tag, "_mem_memread"}, mem_memread, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_write_data"}, mem_write_data, 0);
    check({tag, "_mem_sign_mask"}, mem_sign_mask, 0);
  endtask

  initial begin
    int          s;
    int          w0;
    int          diffs;
    logic [31:0] d;
    logic        mr;
    logic [31:0] a;
    logic [3:0]  m;

    tests = 0; fails = 0; nwrites = 0;
    inflight = 1'b0; prev_should_issue = 1'b0; busy_hold = 0; busy_rand = 1'b0;
    for (int i = 0; i < 256; i++) begin
      phys[i] = 32'hA500_0000 | i;
      arch[i] = phys[i];
    end
    rst_n = 1'b0;
    cpu_addr = '0; cpu_write_data = '0; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
    cpu_sign_mask = '0; mem_busy = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single word store with one busy cycle after issue
    w0 = nwrites;
    do_store(32'h100, 32'h1122_3344, 4'b0100, s);
    check("sw_no_stall", s, 0);
    step();
    step();
    busy_hold = 1;
    drain();
    check("sw_one_write", nwrites - w0, 1);
    check("sw_mem_word", phys[8'h40], 32'h1122_3344);
    check("sw_count_zero", dut.count_q, 0);

    // Five stores into a four-entry buffer while memory is stalled
    w0 = nwrites;
    busy_hold = 8;
    for (int i = 0; i < 5; i++) begin
      do_store(32'h104 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b0100, s);
      if (i < 4) check("fill_no_stall", s, 0);
      else       check("fifth_stall_cycles", s, 6);
    end
    drain();
    check("five_writes", nwrites - w0, 5);

    // Word load forwarded from a pending word store
    busy_hold = 3;
    do_store(32'h200, 32'hDEAD_BEEF, 4'b0100, s);
    do_load(32'h200, 4'b0100, d, s, mr);
    check("fwd_stalls", s, 0);
    check("fwd_mr", mr, 0);
    check("fwd_value", d, 32'hDEAD_BEEF);
    drain();

    // Byte load behind a pending byte store waits for the retire
    busy_hold = 2;
    do_store(32'h201, 32'h0000_00AA, 4'b0000, s);
    do_load(32'h200, 4'b0000, d, s, mr);
    check("lbu_stalled", s > 0, 1);
    check("lbu_mr", mr, 1);
    check("lbu_value", d, 32'hDEAD_AAEF);
    drain();

    // Load with an empty buffer goes straight to memory
    do_load(32'h300, 4'b0100, d, s, mr);
    check("lw_stalls", s, 0);
    check("lw_mr", mr, 1);
    check("lw_value", d, 32'hA500_00C0);

    // Read and write both high is ignored
    cpu_memwrite = 1'b1; cpu_memread = 1'b1;
    cpu_addr = 32'h130; cpu_write_data = 32'h5555_5555; cpu_sign_mask = 4'b0100;
    step();
    cpu_memwrite = 1'b0; cpu_memread = 1'b0;
    step();
    check("both_high_no_enqueue", dut.count_q, 0);

    // Reset while a write is waiting with three entries pending
    do_store(32'h120, 32'h0000_0001, 4'b0100, s);
    do_store(32'h124, 32'h0000_0002, 4'b0100, s);
    do_store(32'h128, 32'h0000_0003, 4'b0100, s);
    busy_hold = 5;
    step();
    check("pre_reset_count", dut.count_q, 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst_count", dut.count_q, 0);
    pend.delete();
    inflight = 1'b0;
    prev_should_issue = 1'b0;
    busy_hold = 0;
    for (int i = 0; i < 256; i++) arch[i] = phys[i];
    @(negedge clk);
    rst_n = 1'b1;
    w0 = nwrites;
    for (int i = 0; i < 6; i++) step();
    check("post_reset_no_writes", nwrites - w0, 0);

    // Random traffic on a small address window
    busy_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      int r;
      int sz;
      r  = $urandom_range(0, 9);
      sz = $urandom_range(0, 2);
      a  = 32'h140 + 32'(4 * $urandom_range(0, 7));
      if (sz == 0)      m = 4'b0100;
      else if (sz == 1) begin m = 4'b0010; a[1] = 1'($urandom_range(0, 1)); end
      else              begin m = 4'b0000; a[1:0] = 2'($urandom_range(0, 3)); end
      m[3] = 1'($urandom_range(0, 1));
      if (r < 4)      do_store(a, $urandom, m, s);
      else if (r < 8) do_load(a, m, d, s, mr);
      else if (r == 8) begin
        cpu_memwrite = 1'b1; cpu_memread = 1'b1;
        cpu_addr = a; cpu_write_data = $urandom; cpu_sign_mask = m;
        step();
        cpu_memwrite = 1'b0; cpu_memread = 1'b0;
      end else step();
    end
    busy_rand = 1'b0;
    drain();
    diffs = 0;
    for (int i = 0; i < 256; i++) if (phys[i] !== arch[i]) diffs++;
    check("final_memory_image", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
